// File: rtl/fft_pkg.sv
// Shared radix-2^2 FFT definitions: feedback-buffer depth helpers for the
// BFI/BFII stages and the complex sample type.
package fft_pkg;

  localparam int DATA_WIDTH = 16;

  typedef struct packed {
    logic signed [DATA_WIDTH-1:0] re;
    logic signed [DATA_WIDTH-1:0] im;
  } cplx_t;

  function automatic int bfi_depth(input int n, input int stage);
    return n >> (2 * stage + 1);
  endfunction

  function automatic int bfii_depth(input int n, input int stage);
    return n >> (2 * stage + 2);
  endfunction

endpackage

// File: rtl/fft_ctrl_cnt.sv
// Valid-gated sample counter k = {s_o, t_o, idx_o} that wraps every 4*DEPTH
// accepted samples; primed_o rises once the first DEPTH samples are in.
module fft_ctrl_cnt
  import fft_pkg::*;
#(
  parameter  int DEPTH = 4,
  localparam int DB    = (DEPTH > 1) ? $clog2(DEPTH) : 0,
  localparam int IW    = (DB > 0) ? DB : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en_i,
  output logic [IW-1:0] idx_o,
  output logic          t_o,
  output logic          s_o,
  output logic          primed_o
);

  localparam int KW = DB + 2;

  logic [KW-1:0] k_q, k_d;
  logic          primed_q, primed_d;

  always_comb begin
    k_d      = k_q;
    primed_d = primed_q;
    if (en_i) begin
      k_d = k_q + KW'(1);
      if (k_q == KW'(DEPTH - 1)) primed_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      k_q      <= '0;
      primed_q <= 1'b0;
    end else begin
      k_q      <= k_d;
      primed_q <= primed_d;
    end
  end

  assign t_o      = k_q[DB];
  assign s_o      = k_q[DB+1];
  assign primed_o = primed_q;

  // A single-entry buffer has no address bits, so its index is pinned to 0.
  generate
    if (DB == 0) begin : g_idx_const
      assign idx_o = '0;
    end else begin : g_idx
      assign idx_o = k_q[IW-1:0];
    end
  endgenerate

endmodule

// File: rtl/bfii.sv
// Radix-2^2 SDF butterfly type II: -j rotation plus add/subtract against a
// feedback buffer. Define BFII_SCALE_EN to halve butterfly results (no growth).
module bfii
  import fft_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int N_POINTS   = 16,
  parameter int STAGE      = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_val,
  input  logic [DATA_WIDTH-1:0] in_re,
  input  logic [DATA_WIDTH-1:0] in_im,
  output logic                  out_val,
  output logic [DATA_WIDTH-1:0] out_re,
  output logic [DATA_WIDTH-1:0] out_im
);

  localparam int D     = bfii_depth(N_POINTS, STAGE);
  localparam int DSAFE = (D < 1) ? 1 : D;
  localparam int DB    = (DSAFE > 1) ? $clog2(DSAFE) : 0;
  localparam int IW    = (DB > 0) ? DB : 1;

  generate
    if (D < 1) begin : g_depth_check
      $error("bfii: buffer depth N_POINTS>>(2*STAGE+2) must be at least 1");
    end
  endgenerate

  logic [IW-1:0] idx;
  logic          tCtl, sCtl, primed;

  fft_ctrl_cnt #(.DEPTH(DSAFE)) u_ctrl (
    .clk      (clk),
    .rst      (rst),
    .en_i     (in_val),
    .idx_o    (idx),
    .t_o      (tCtl),
    .s_o      (sCtl),
    .primed_o (primed)
  );

  logic signed [DATA_WIDTH-1:0] bufRe_q [DSAFE];
  logic signed [DATA_WIDTH-1:0] bufIm_q [DSAFE];
  logic                         outVal_q, outVal_d;
  logic signed [DATA_WIDTH-1:0] outRe_q, outRe_d, outIm_q, outIm_d;
  logic signed [DATA_WIDTH-1:0] inRe, inIm, xRe, xIm, rdRe, rdIm;
  logic signed [DATA_WIDTH-1:0] sumRe, sumIm, difRe, difIm, wrRe, wrIm;

  assign inRe = $signed(in_re);
  assign inIm = $signed(in_im);
  assign rdRe = bufRe_q[idx];
  assign rdIm = bufIm_q[idx];

  // -j * (re, im) = (im, -re); negating the most-negative value wraps to itself.
  always_comb begin
    xRe = inRe;
    xIm = inIm;
    if (tCtl && sCtl) begin
      xRe = inIm;
      xIm = -inRe;
    end
  end

`ifdef BFII_SCALE_EN
  logic signed [DATA_WIDTH:0] sumReW, sumImW, difReW, difImW;

  assign sumReW = {rdRe[DATA_WIDTH-1], rdRe} + {xRe[DATA_WIDTH-1], xRe};
  assign sumImW = {rdIm[DATA_WIDTH-1], rdIm} + {xIm[DATA_WIDTH-1], xIm};
  assign difReW = {rdRe[DATA_WIDTH-1], rdRe} - {xRe[DATA_WIDTH-1], xRe};
  assign difImW = {rdIm[DATA_WIDTH-1], rdIm} - {xIm[DATA_WIDTH-1], xIm};
  assign sumRe  = sumReW[DATA_WIDTH:1];
  assign sumIm  = sumImW[DATA_WIDTH:1];
  assign difRe  = difReW[DATA_WIDTH:1];
  assign difIm  = difImW[DATA_WIDTH:1];
`else
  assign sumRe = rdRe + xRe;
  assign sumIm = rdIm + xIm;
  assign difRe = rdRe - xRe;
  assign difIm = rdIm - xIm;
`endif

  always_comb begin
    outVal_d = in_val & (primed | tCtl);
    outRe_d  = outRe_q;
    outIm_d  = outIm_q;
    wrRe     = inRe;
    wrIm     = inIm;
    if (in_val) begin
      if (tCtl) begin
        outRe_d = sumRe;
        outIm_d = sumIm;
        wrRe    = difRe;
        wrIm    = difIm;
      end else begin
        outRe_d = rdRe;
        outIm_d = rdIm;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      outVal_q <= 1'b0;
      outRe_q  <= '0;
      outIm_q  <= '0;
      for (int i = 0; i < DSAFE; i++) begin
        bufRe_q[i] <= '0;
        bufIm_q[i] <= '0;
      end
    end else begin
      outVal_q <= outVal_d;
      outRe_q  <= outRe_d;
      outIm_q  <= outIm_d;
      if (in_val) begin
        bufRe_q[idx] <= wrRe;
        bufIm_q[idx] <= wrIm;
      end
    end
  end

  assign out_val = outVal_q;
  assign out_re  = outRe_q;
  assign out_im  = outIm_q;

endmodule

// File: tb/tb_bfii.sv
// Directed bench for bfii: N=16 STAGE=0 (D=4) main instance plus an
// N=16 STAGE=1 (D=1) instance sharing the same input stream.
module tb_bfii;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        inVal = 1'b0;
  logic [15:0] inRe = '0, inIm = '0;
  logic        outVal0, outVal1;
  logic [15:0] outRe0, outIm0, outRe1, outIm1;

  int errCount = 0;
  int checkCount = 0;

  logic [15:0] rampRe [16];
  logic [15:0] rampIm [16];
  logic        rampVal [16];

  always #5 clk = ~clk;

  bfii #(.DATA_WIDTH(16), .N_POINTS(16), .STAGE(0)) dut0 (
    .clk(clk), .rst(rst), .in_val(inVal), .in_re(inRe), .in_im(inIm),
    .out_val(outVal0), .out_re(outRe0), .out_im(outIm0)
  );

  bfii #(.DATA_WIDTH(16), .N_POINTS(16), .STAGE(1)) dut1 (
    .clk(clk), .rst(rst), .in_val(inVal), .in_re(inRe), .in_im(inIm),
    .out_val(outVal1), .out_re(outRe1), .out_im(outIm1)
  );

  // Every comparison funnels through here so the counts stay consistent.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errCount++;
      $display("[TB] FAIL %s: got 0x%0h, want 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic v, input logic [15:0] re,
                               input logic [15:0] im);
    inVal = v;
    inRe  = re;
    inIm  = im;
    @(posedge clk);
    #1;
  endtask

  task automatic doReset();
    #1;
    rst   = 1'b0;
    inVal = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  task automatic checkRampStep(input int i, input string tag);
    checkOutput($sformatf("%s_val%0d", tag, i), 32'(outVal0), 32'(rampVal[i]));
    checkOutput($sformatf("%s_re%0d", tag, i), 32'(outRe0), 32'(rampRe[i]));
    checkOutput($sformatf("%s_im%0d", tag, i), 32'(outIm0), 32'(rampIm[i]));
  endtask

  task automatic runRamp(input int n, input bit gaps, input string tag);
    for (int i = 0; i < n; i++) begin
      applyStimulus(1'b1, 16'(i + 1), 16'h0000);
      checkRampStep(i, tag);
      if (gaps) begin
        applyStimulus(1'b0, 16'h1234, 16'h5678);
        checkOutput($sformatf("%s_gapval%0d", tag, i), 32'(outVal0), 32'h0);
        checkOutput($sformatf("%s_gapre%0d", tag, i), 32'(outRe0), 32'(rampRe[i]));
        checkOutput($sformatf("%s_gapim%0d", tag, i), 32'(outIm0), 32'(rampIm[i]));
      end
    end
  endtask

  initial begin
    // Ramp 1..16 through D=4: silent fill, sums, held differences, then -j pairs.
    for (int i = 0; i < 16; i++) begin
      rampVal[i] = (i >= 4);
      rampIm[i]  = 16'h0000;
      if (i < 4)       rampRe[i] = 16'h0000;
      else if (i < 8)  rampRe[i] = 16'(2 * i - 2);
      else if (i < 12) rampRe[i] = 16'hFFFC;
      else begin
        rampRe[i] = 16'(i - 3);
        rampIm[i] = 16'(-(i + 1));
      end
    end

    rst = 1'b0;
    for (int c = 0; c < 4; c++) begin
      inVal = 1'b1;
      inRe  = 16'($urandom);
      inIm  = 16'($urandom);
      @(posedge clk);
      #1;
      checkOutput($sformatf("rst_val%0d", c), 32'(outVal0), 32'h0);
      checkOutput($sformatf("rst_re%0d", c), 32'(outRe0), 32'h0);
      checkOutput($sformatf("rst_im%0d", c), 32'(outIm0), 32'h0);
      checkOutput($sformatf("rst1_val%0d", c), 32'(outVal1), 32'h0);
    end
    inVal = 1'b0;
    rst = 1'b1;

    runRamp(16, 1'b0, "ramp");

    doReset();
    runRamp(16, 1'b1, "gap");

    // Reset in the middle of a frame must discard all buffered state.
    doReset();
    runRamp(10, 1'b0, "pre");
    rst   = 1'b0;
    inVal = 1'b0;
    #1;
    checkOutput("midrst_val", 32'(outVal0), 32'h0);
    checkOutput("midrst_re", 32'(outRe0), 32'h0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    runRamp(16, 1'b0, "post");

    // Overflow: 0x7FFF + 0x7FFF wraps, and -j of 0x8000 wraps to itself.
    doReset();
    applyStimulus(1'b1, 16'h7FFF, 16'h0000);
    for (int i = 1; i < 4; i++) applyStimulus(1'b1, 16'h0000, 16'h0000);
    applyStimulus(1'b1, 16'h7FFF, 16'h0000);
    checkOutput("wrap_val", 32'(outVal0), 32'h1);
`ifdef BFII_SCALE_EN
    checkOutput("wrap_re", 32'(outRe0), 32'h7FFF);
`else
    checkOutput("wrap_re", 32'(outRe0), 32'hFFFE);
`endif
    checkOutput("wrap_im", 32'(outIm0), 32'h0);
    for (int i = 5; i < 12; i++) applyStimulus(1'b1, 16'h0000, 16'h0000);
    applyStimulus(1'b1, 16'h8000, 16'h0000);
    checkOutput("negwrap_re", 32'(outRe0), 32'h0);
`ifdef BFII_SCALE_EN
    checkOutput("negwrap_im", 32'(outIm0), 32'hC000);
`else
    checkOutput("negwrap_im", 32'(outIm0), 32'h8000);
`endif

    // STAGE=1 instance (D=1): 1,2,3,4 then one sample of the next frame.
    doReset();
    applyStimulus(1'b1, 16'd1, 16'h0000);
    checkOutput("s1_val0", 32'(outVal1), 32'h0);
    applyStimulus(1'b1, 16'd2, 16'h0000);
    checkOutput("s1_val1", 32'(outVal1), 32'h1);
    checkOutput("s1_re1", 32'(outRe1), 32'h0003);
    checkOutput("s1_im1", 32'(outIm1), 32'h0000);
    applyStimulus(1'b1, 16'd3, 16'h0000);
    checkOutput("s1_val2", 32'(outVal1), 32'h1);
    checkOutput("s1_re2", 32'(outRe1), 32'hFFFF);
    checkOutput("s1_im2", 32'(outIm1), 32'h0000);
    applyStimulus(1'b1, 16'd4, 16'h0000);
    checkOutput("s1_val3", 32'(outVal1), 32'h1);
    checkOutput("s1_re3", 32'(outRe1), 32'h0003);
    checkOutput("s1_im3", 32'(outIm1), 32'hFFFC);
    applyStimulus(1'b1, 16'd0, 16'h0000);
    checkOutput("s1_val4", 32'(outVal1), 32'h1);
    checkOutput("s1_re4", 32'(outRe1), 32'h0003);
    checkOutput("s1_im4", 32'(outIm1), 32'h0004);
    applyStimulus(1'b0, 16'h0000, 16'h0000);
    checkOutput("s1_gapval", 32'(outVal1), 32'h0);

    $display("Result: errors=%0d of %0d checks", errCount, checkCount);
    $finish;
  end

endmodule
